pc_sequencer: RTL and testbench

//  Upstream neighbour of the instruction fetch unit: owns the program counter, issues one fetch

---
 rtl/pc_sequencer_if.sv | 27 ++
 rtl/pc_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_pc_sequencer.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// Fetch-side handshake and status bundle between the PC sequencer and its neighbours.
// master = sequencer side, slave = fetch unit / environment side.
interface pc_sequencer_if;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        stat_instruction_fetched;
    logic        ctr_mem_read_enable;
    logic [31:0] pc;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_count;
    logic        stat_misaligned;
    logic        stat_fetch_timeout;

    modport master (
        input  stall, redirect_valid, redirect_target, stat_instruction_fetched,
        output ctr_mem_read_enable, pc, fetch_valid, fetch_pc, fetch_count,
               stat_misaligned, stat_fetch_timeout
    );

    modport slave (
        output stall, redirect_valid, redirect_target, stat_instruction_fetched,
        input  ctr_mem_read_enable, pc, fetch_valid, fetch_pc, fetch_count,
               stat_misaligned, stat_fetch_timeout
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter sequencer: one outstanding fetch, PC+4 stepping, redirects with squash, misalign halt.
// Optional fetch timeout enabled by defining PC_FETCH_TIMEOUT_EN.
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
`ifdef PC_FETCH_TIMEOUT_EN
    ,
    parameter int unsigned FETCH_TIMEOUT = 16
`endif
) (
    input  logic           clk,
    input  logic           reset,
    pc_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_WAIT   = 3'd2,
        S_SQUASH = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        fetch_valid_q, fetch_valid_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] fetch_count_q, fetch_count_d;
    logic        misaligned_q, misaligned_d;

    logic redir;
    logic fetched;
    logic tgt_misaligned;

    assign redir          = bus.redirect_valid;
    assign fetched        = bus.stat_instruction_fetched;
    assign tgt_misaligned = |bus.redirect_target[1:0];

`ifdef PC_FETCH_TIMEOUT_EN
    logic [31:0] tmo_cnt_q, tmo_cnt_d;
    logic        timeout_q, timeout_d;
    logic        tmo_expired;

    assign tmo_expired = (tmo_cnt_q == FETCH_TIMEOUT - 1);
`endif

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        fetch_valid_d = 1'b0;
        fetch_pc_d    = fetch_pc_q;
        fetch_count_d = fetch_count_q;
        misaligned_d  = misaligned_q;
`ifdef PC_FETCH_TIMEOUT_EN
        tmo_cnt_d     = tmo_cnt_q;
        timeout_d     = timeout_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                state_d = S_ISSUE;
            end

            S_ISSUE: begin
                if (redir) begin
                    pc_d = bus.redirect_target;
                    if (tgt_misaligned) begin
                        misaligned_d = 1'b1;
                        state_d      = S_HALT;
                    end
                end else if (!bus.stall) begin
                    state_d = S_WAIT;
`ifdef PC_FETCH_TIMEOUT_EN
                    tmo_cnt_d = 32'd0;
`endif
                end
            end

            S_WAIT: begin
                if (redir) begin
                    pc_d = bus.redirect_target;
`ifdef PC_FETCH_TIMEOUT_EN
                    tmo_cnt_d = 32'd0;
`endif
                    if (tgt_misaligned) begin
                        misaligned_d = 1'b1;
                        state_d      = S_HALT;
                    end else if (fetched) begin
                        // The fetch landed this cycle, so nothing is left to squash.
                        state_d = S_ISSUE;
                    end else begin
                        state_d = S_SQUASH;
                    end
                end else if (fetched) begin
                    fetch_valid_d = 1'b1;
                    fetch_pc_d    = pc_q;
                    fetch_count_d = fetch_count_q + 32'd1;
                    pc_d          = pc_q + 32'd4;
                    state_d       = S_ISSUE;
                end
`ifdef PC_FETCH_TIMEOUT_EN
                else if (tmo_expired) begin
                    timeout_d = 1'b1;
                    state_d   = S_ISSUE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 32'd1;
                end
`endif
            end

            S_SQUASH: begin
                if (redir) begin
                    pc_d = bus.redirect_target;
`ifdef PC_FETCH_TIMEOUT_EN
                    tmo_cnt_d = 32'd0;
`endif
                    if (tgt_misaligned) begin
                        misaligned_d = 1'b1;
                        state_d      = S_HALT;
                    end else if (fetched) begin
                        // Squashed fetch retired together with the new redirect: nothing outstanding.
                        state_d = S_ISSUE;
                    end
                end else if (fetched) begin
                    state_d = S_ISSUE;
                end
`ifdef PC_FETCH_TIMEOUT_EN
                else if (tmo_expired) begin
                    timeout_d = 1'b1;
                    state_d   = S_ISSUE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 32'd1;
                end
`endif
            end

            S_HALT: begin
                state_d = S_HALT;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_VECTOR;
            fetch_valid_q <= 1'b0;
            fetch_pc_q    <= 32'd0;
            fetch_count_q <= 32'd0;
            misaligned_q  <= 1'b0;
`ifdef PC_FETCH_TIMEOUT_EN
            tmo_cnt_q     <= 32'd0;
            timeout_q     <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_pc_q    <= fetch_pc_d;
            fetch_count_q <= fetch_count_d;
            misaligned_q  <= misaligned_d;
`ifdef PC_FETCH_TIMEOUT_EN
            tmo_cnt_q     <= tmo_cnt_d;
            timeout_q     <= timeout_d;
`endif
        end
    end

    // Request is combinational so a same-cycle stall or redirect can suppress a stale-PC fetch.
    assign bus.ctr_mem_read_enable = (state_q == S_ISSUE) && !bus.stall && !redir;
    assign bus.pc                  = pc_q;
    assign bus.fetch_valid         = fetch_valid_q;
    assign bus.fetch_pc            = fetch_pc_q;
    assign bus.fetch_count         = fetch_count_q;
    assign bus.stat_misaligned     = misaligned_q;
`ifdef PC_FETCH_TIMEOUT_EN
    assign bus.stat_fetch_timeout  = timeout_q;
`else
    assign bus.stat_fetch_timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed, table-driven bench for pc_sequencer plus hand sequences for reset, halt and timeout corners.
module tb_pc_sequencer;

    logic clk;
    logic reset;

    pc_sequencer_if bus ();

    pc_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        redir;
        logic [31:0] tgt;
        logic        fet;
        logic        req;
        logic [31:0] pc;
        logic        fv;
        logic [31:0] fpc;
        logic [31:0] cnt;
        logic        mis;
    } vec_t;

    vec_t vq[$];
    int   n_pass;
    int   n_total;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        else
            n_pass++;
    endtask

    task automatic add(input logic st, input logic rd, input logic [31:0] tg, input logic ft,
                       input logic rq, input logic [31:0] p, input logic f, input logic [31:0] fp,
                       input logic [31:0] c, input logic m);
        vq.push_back('{st, rd, tg, ft, rq, p, f, fp, c, m});
    endtask

    // Drive one cycle of inputs (reset low) on the falling edge, then settle before checks.
    task automatic drive(input logic st, input logic rd, input logic [31:0] tg, input logic ft);
        @(negedge clk);
        reset                        = 1'b0;
        bus.stall                    = st;
        bus.redirect_valid           = rd;
        bus.redirect_target          = tg;
        bus.stat_instruction_fetched = ft;
        #2;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset                        = 1'b1;
        bus.stall                    = 1'b0;
        bus.redirect_valid           = 1'b0;
        bus.redirect_target          = 32'd0;
        bus.stat_instruction_fetched = 1'b0;
        @(negedge clk);
        #2;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_req"}, {31'd0, bus.ctr_mem_read_enable}, 32'd0);
        chk({tag, "_pc"},  bus.pc, 32'h0000_0000);
        chk({tag, "_fv"},  {31'd0, bus.fetch_valid}, 32'd0);
        chk({tag, "_fpc"}, bus.fetch_pc, 32'd0);
        chk({tag, "_cnt"}, bus.fetch_count, 32'd0);
        chk({tag, "_mis"}, {31'd0, bus.stat_misaligned}, 32'd0);
        chk({tag, "_tmo"}, {31'd0, bus.stat_fetch_timeout}, 32'd0);
        $display("reset check %s: pc=%h cnt=%0d", tag, bus.pc, bus.fetch_count);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_pass  = 0;
        n_total = 0;
        reset                        = 1'b1;
        bus.stall                    = 1'b0;
        bus.redirect_valid           = 1'b0;
        bus.redirect_target          = 32'd0;
        bus.stat_instruction_fetched = 1'b0;

        //   stall redir target        fet | req pc            fv fpc           cnt mis
        add(0, 0, 32'h0,          1,  0, 32'h0,          0, 32'h0,          0, 0); // IDLE
        add(0, 0, 32'h0,          1,  1, 32'h0,          0, 32'h0,          0, 0);
        add(0, 0, 32'h0,          1,  0, 32'h0,          0, 32'h0,          0, 0);
        add(0, 0, 32'h0,          1,  1, 32'h4,          1, 32'h0,          1, 0);
        add(0, 0, 32'h0,          1,  0, 32'h4,          0, 32'h0,          1, 0);
        add(0, 0, 32'h0,          1,  1, 32'h8,          1, 32'h4,          2, 0);
        add(0, 0, 32'h0,          1,  0, 32'h8,          0, 32'h4,          2, 0);
        add(0, 0, 32'h0,          1,  1, 32'hC,          1, 32'h8,          3, 0);
        add(0, 0, 32'h0,          1,  0, 32'hC,          0, 32'h8,          3, 0);
        add(0, 0, 32'h0,          0,  1, 32'h10,         1, 32'hC,          4, 0);
        add(0, 1, 32'h200,        0,  0, 32'h10,         0, 32'hC,          4, 0); // redirect in WAIT
        add(0, 0, 32'h0,          0,  0, 32'h200,        0, 32'hC,          4, 0); // SQUASH
        add(0, 0, 32'h0,          0,  0, 32'h200,        0, 32'hC,          4, 0);
        add(0, 0, 32'h0,          1,  0, 32'h200,        0, 32'hC,          4, 0);
        for (int i = 0; i < 5; i++)
            add(1, 0, 32'h0,      0,  0, 32'h200,        0, 32'hC,          4, 0); // stalled ISSUE
        add(0, 0, 32'h0,          0,  1, 32'h200,        0, 32'hC,          4, 0);
        add(0, 1, 32'h300,        1,  0, 32'h200,        0, 32'hC,          4, 0); // redirect + fetched
        add(1, 1, 32'h400,        0,  0, 32'h300,        0, 32'hC,          4, 0); // redirect beats stall
        add(0, 0, 32'h0,          1,  1, 32'h400,        0, 32'hC,          4, 0);
        add(0, 0, 32'h0,          1,  0, 32'h400,        0, 32'hC,          4, 0);
        add(0, 0, 32'h0,          0,  1, 32'h404,        1, 32'h400,        5, 0);
        add(0, 1, 32'hFFFF_FFFC,  0,  0, 32'h404,        0, 32'h400,        5, 0);
        add(0, 0, 32'h0,          1,  0, 32'hFFFF_FFFC,  0, 32'h400,        5, 0);
        add(0, 0, 32'h0,          1,  1, 32'hFFFF_FFFC,  0, 32'h400,        5, 0);
        add(0, 0, 32'h0,          1,  0, 32'hFFFF_FFFC,  0, 32'h400,        5, 0);
        add(0, 0, 32'h0,          0,  1, 32'h0,          1, 32'hFFFF_FFFC,  6, 0); // pc wrapped
        add(0, 1, 32'h202,        0,  0, 32'h0,          0, 32'hFFFF_FFFC,  6, 0); // misaligned
        add(0, 1, 32'h500,        1,  0, 32'h202,        0, 32'hFFFF_FFFC,  6, 1); // HALT
        add(0, 0, 32'h0,          1,  0, 32'h202,        0, 32'hFFFF_FFFC,  6, 1);
        add(0, 0, 32'h0,          0,  0, 32'h202,        0, 32'hFFFF_FFFC,  6, 1);

        @(negedge clk);
        #2;
        chk_reset_state("init");

        foreach (vq[i]) begin
            drive(vq[i].stall, vq[i].redir, vq[i].tgt, vq[i].fet);
            chk($sformatf("v%0d_req", i), {31'd0, bus.ctr_mem_read_enable}, {31'd0, vq[i].req});
            chk($sformatf("v%0d_pc", i),  bus.pc, vq[i].pc);
            chk($sformatf("v%0d_fv", i),  {31'd0, bus.fetch_valid}, {31'd0, vq[i].fv});
            chk($sformatf("v%0d_fpc", i), bus.fetch_pc, vq[i].fpc);
            chk($sformatf("v%0d_cnt", i), bus.fetch_count, vq[i].cnt);
            chk($sformatf("v%0d_mis", i), {31'd0, bus.stat_misaligned}, {31'd0, vq[i].mis});
            chk($sformatf("v%0d_tmo", i), {31'd0, bus.stat_fetch_timeout}, 32'd0);
            $display("vec %0d: st=%0b rd=%0b tgt=%h fet=%0b -> req=%0b pc=%h fv=%0b fpc=%h cnt=%0d mis=%0b",
                     i, vq[i].stall, vq[i].redir, vq[i].tgt, vq[i].fet, bus.ctr_mem_read_enable,
                     bus.pc, bus.fetch_valid, bus.fetch_pc, bus.fetch_count, bus.stat_misaligned);
        end

        // Reset out of HALT clears the sticky flag.
        do_reset();
        chk_reset_state("rst_halt");

        // Misaligned redirect taken directly from ISSUE.
        drive(0, 0, 32'h0, 0);
        drive(0, 1, 32'h1, 0);
        chk("iss_mis_req", {31'd0, bus.ctr_mem_read_enable}, 32'd0);
        drive(0, 0, 32'h0, 1);
        chk("iss_mis_flag", {31'd0, bus.stat_misaligned}, 32'd1);
        chk("iss_mis_pc", bus.pc, 32'h1);
        chk("iss_mis_halt_req", {31'd0, bus.ctr_mem_read_enable}, 32'd0);
        $display("issue misalign: pc=%h mis=%0b", bus.pc, bus.stat_misaligned);

        // Reset while a fetch is outstanding.
        do_reset();
        drive(0, 0, 32'h0, 1);
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 32'h0, 1);
            drive(0, 0, 32'h0, 1);
        end
        drive(0, 0, 32'h0, 0);
        drive(0, 0, 32'h0, 0);
        chk("midwait_pc", bus.pc, 32'h8);
        chk("midwait_fpc", bus.fetch_pc, 32'h4);
        chk("midwait_cnt", bus.fetch_count, 32'd2);
        $display("mid-wait before reset: pc=%h fpc=%h cnt=%0d", bus.pc, bus.fetch_pc, bus.fetch_count);
        do_reset();
        chk_reset_state("rst_wait");

        // Fetch never completes: timeout with the feature, indefinite wait without.
        drive(0, 0, 32'h0, 0);
        drive(0, 0, 32'h0, 0);
        chk("tmo_first_req", {31'd0, bus.ctr_mem_read_enable}, 32'd1);
        for (int k = 1; k <= 16; k++)
            drive(0, 0, 32'h0, 0);
        chk("tmo_c16_flag", {31'd0, bus.stat_fetch_timeout}, 32'd0);
        chk("tmo_c16_req", {31'd0, bus.ctr_mem_read_enable}, 32'd0);
        drive(0, 0, 32'h0, 0);
`ifdef PC_FETCH_TIMEOUT_EN
        chk("tmo_flag", {31'd0, bus.stat_fetch_timeout}, 32'd1);
        chk("tmo_rereq", {31'd0, bus.ctr_mem_read_enable}, 32'd1);
`else
        chk("tmo_flag", {31'd0, bus.stat_fetch_timeout}, 32'd0);
        chk("tmo_rereq", {31'd0, bus.ctr_mem_read_enable}, 32'd0);
`endif
        chk("tmo_pc", bus.pc, 32'h0);
        chk("tmo_fv", {31'd0, bus.fetch_valid}, 32'd0);
        $display("timeout probe: tmo=%0b req=%0b pc=%h", bus.stat_fetch_timeout,
                 bus.ctr_mem_read_enable, bus.pc);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
